bip_result_uart_tx: RTL and testbench

Downstream stage of the BIP processor top (`full_top`). It watches the processor's halt `flag` and result word `o_Data`. On the halt rising edge it latches the result together with a cycle count measured from reset release, then serializes a fixed 6-byte frame out of an 8N1 UART transmitter so the host can read the program result. It is the only path from the processor result to the board pin.

---
 rtl/bip_result_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_bip_result_uart_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bip_result_uart_tx.sv
// Result frame transmitter for the BIP processor top.
// Latches result and run-cycle count on halt, then sends a 6-byte 8N1 frame.
module bip_result_uart_tx #(
    parameter int         DATA_LENGTH  = 16,
    parameter int         CNT_BITS     = 16,
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_flag,
    input  logic [DATA_LENGTH-1:0] i_data,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BYTE = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [2:0]             byte_q, byte_d;
    logic                   flag_q;
    logic [CNT_BITS-1:0]    run_cnt_q;
    logic [DATA_LENGTH-1:0] data_q;
    logic [CNT_BITS-1:0]    cnt_lat_q;
    logic [7:0]             chk_q;
    logic                   rise;
    logic                   accept;
    logic                   baud_end;
    logic                   tx_d;
    logic                   busy_d;
    logic [7:0]             cur_byte;

    assign rise     = i_flag & ~flag_q;
    assign accept   = rise & ((state_q == IDLE) | (state_q == DONE));
    assign baud_end = (baud_q == BAUD_MAX);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            flag_q    <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            flag_q <= i_flag;
            if (!i_flag && run_cnt_q != '1)
                run_cnt_q <= run_cnt_q + CNT_BITS'(1);
        end
    end

    // Frame contents are frozen at the accepted start edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            data_q    <= '0;
            cnt_lat_q <= '0;
            chk_q     <= '0;
        end else if (accept) begin
            data_q    <= i_data;
            cnt_lat_q <= run_cnt_q;
            chk_q     <= i_data[15:8] ^ i_data[7:0]
                       ^ run_cnt_q[15:8] ^ run_cnt_q[7:0];
        end
    end

    always_comb begin
        cur_byte = HEADER;
        unique case (byte_q)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = data_q[15:8];
            3'd2:    cur_byte = data_q[7:0];
            3'd3:    cur_byte = cnt_lat_q[15:8];
            3'd4:    cur_byte = cnt_lat_q[7:0];
            3'd5:    cur_byte = chk_q;
            default: cur_byte = HEADER;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            o_tx    <= tx_d;
            o_busy  <= busy_d;
            o_done  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        unique case (state_q)
            IDLE, DONE: begin
                baud_d = '0;
                if (accept) begin
                    state_d = START;
                    byte_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = DONE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = START;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is computed from the next state so the pin is a flop.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        unique case (state_d)
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = cur_byte[bit_d];
                busy_d = 1'b1;
            end
            STOP: begin
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bip_result_uart_tx.sv
// Bench for bip_result_uart_tx: frame scoreboard plus UART line decoder.
// Expected frames come from a count-and-xor model of the result frame.
module tb_bip_result_uart_tx;

    localparam int CPB        = 4;
    localparam int FRAME_CLKS = 60 * CPB;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        flag = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        tx;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q[$];
    int unsigned ref_cnt = 0;

    int   starts     = 0;
    int   done_rises = 0;
    bit   m_active   = 1'b0;
    int   m_cnt      = 0;
    logic [7:0] m_byte = 8'h00;
    logic prev_busy  = 1'b0;
    logic prev_done  = 1'b0;
    int   busy_len   = 0;

    bip_result_uart_tx #(
        .DATA_LENGTH (16),
        .CNT_BITS    (16),
        .CLKS_PER_BIT(CPB),
        .HEADER      (8'hA5)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_flag (flag),
        .i_data (data),
        .o_tx   (tx),
        .o_busy (busy),
        .o_done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: clock edges with the flag low since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            ref_cnt <= 0;
        else if (!flag)
            ref_cnt <= ref_cnt + 1;
    end

    task automatic push_frame(input logic [15:0] d);
        logic [15:0] c;
        c = (ref_cnt > 32'd65535) ? 16'hFFFF : ref_cnt[15:0];
        exp_q.push_back(8'hA5);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(d[15:8] ^ d[7:0] ^ c[15:8] ^ c[7:0]);
    endtask

    // Monitor: decodes the line at mid-bit and checks frame timing.
    always @(negedge clk) begin
        if (!rst) begin
            m_active  = 1'b0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
            busy_len  = 0;
        end else begin
            if (busy && !prev_busy) starts++;
            if (done && !prev_done) done_rises++;
            if (busy) busy_len++;
            if (!busy && prev_busy) begin
                chk("busy_len", busy_len, FRAME_CLKS);
                chk("done_at_end", {31'd0, done}, 1);
                busy_len = 0;
            end
            prev_busy = busy;
            prev_done = done;
            if (!m_active) begin
                if (tx == 1'b0) begin
                    m_active = 1'b1;
                    m_cnt    = 0;
                end
            end else begin
                m_cnt++;
            end
            if (m_active && (m_cnt % CPB) == 1) begin
                int idx;
                idx = m_cnt / CPB;
                if (idx == 0) begin
                    chk("start_bit", {31'd0, tx}, 0);
                end else if (idx <= 8) begin
                    m_byte[idx-1] = tx;
                end else begin
                    chk("stop_bit", {31'd0, tx}, 1);
                    m_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %0h expected none",
                                 m_byte);
                    end else begin
                        chk("frame_byte", m_byte, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_frame(input string name);
        bit ok;
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < FRAME_CLKS + 40; i++) begin
            @(negedge clk);
            if (done && !busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_complete"}, {31'd0, ok}, 1);
    endtask

    initial begin
        int s0;
        int d0;

        // Reset state and idle line after release
        repeat (5) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i < 50) begin
                chk("idle_tx", {31'd0, tx}, 1);
                chk("idle_busy", {31'd0, busy}, 0);
                chk("idle_done", {31'd0, done}, 0);
            end
        end

        // Result 1234 after 100 low-flag clocks
        data = 16'h1234;
        flag = 1'b1;
        push_frame(data);
        wait_frame("t2");

        // Flag already high at reset release
        rst  = 1'b0;
        flag = 1'b1;
        data = 16'hFFFF;
        repeat (3) @(negedge clk);
        push_frame(data);
        rst = 1'b1;
        wait_frame("t3");

        // Saturated counter
        rst  = 1'b0;
        flag = 1'b0;
        data = 16'h0001;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (70000) @(negedge clk);
        flag = 1'b1;
        push_frame(data);
        wait_frame("t4");

        // Asynchronous reset in the middle of byte 2
        flag = 1'b0;
        repeat (10) @(negedge clk);
        data = 16'($urandom);
        flag = 1'b1;
        push_frame(data);
        repeat (95) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        push_frame(data);
        rst = 1'b1;
        wait_frame("t5");

        // Input activity during a frame is ignored
        flag = 1'b0;
        repeat (20) @(negedge clk);
        data = 16'($urandom);
        s0   = starts;
        d0   = done_rises;
        flag = 1'b1;
        push_frame(data);
        repeat (60) @(negedge clk);
        flag = 1'b0;
        repeat (2) @(negedge clk);
        data = 16'h5555;
        flag = 1'b1;
        wait_frame("t6");
        repeat (300) @(negedge clk);
        chk("t6_starts", starts - s0, 1);
        chk("t6_done_rises", done_rises - d0, 1);

        // Randomized back-to-back results
        for (int n = 0; n < 5; n++) begin
            flag = 1'b0;
            repeat ($urandom_range(1, 200)) @(negedge clk);
            data = 16'($urandom);
            flag = 1'b1;
            push_frame(data);
            wait_frame("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
